// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window on the core's
// data-memory port, a small byte FIFO and a serializer FSM driving tx.
//
// state | meaning
// IDLE  | line high; pops the FIFO head when enabled and a byte is queued
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          overflow, enable;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud;

  logic [29:0] word_off;
  logic [1:0]  reg_idx;
  logic        wr_txdata, wr_ctrl;
  logic        full, empty, busy, pop, push_ok;
  logic [7:0]  count8;
  logic [31:0] status;
  logic        unused_bits;

  // Unsigned offset from the base word; anything below the base wraps high.
  assign word_off = a[31:2] - BASE_ADDR[31:2];
  assign sel      = (word_off < 30'd3);
  assign reg_idx  = word_off[1:0];

  assign wr_txdata = we & sel & (reg_idx == 2'd0);
  assign wr_ctrl   = we & sel & (reg_idx == 2'd2);

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign pop     = (state == IDLE) & enable & ~empty;
  assign push_ok = wr_txdata & (~full | pop);

  assign count8 = 8'(count);
  assign status = {16'h0, count8, 3'b000, enable, overflow, full, empty, busy};

  always_comb begin
    rd = '0;
    if (sel) begin
      case (reg_idx)
        2'd1:    rd = status;
        2'd2:    rd = {31'b0, enable};
        default: rd = '0;
      endcase
    end
  end

  assign unused_bits = ^{a[1:0], wd[31:8]};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_txdata & full & ~pop) overflow <= 1'b1;
      if (wr_ctrl) begin
        enable <= wd[0];
        if (wd[1]) overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            shift   <= mem[rptr];
            bit_idx <= '0;
            baud    <= '0;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register-access vector table, directed frame
// sequences, and randomized traffic against a queue-based frame-timing model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0080;
  localparam int C = 4;
  localparam int D = 4;

  logic        clk, reset, we, sel, tx;
  logic [31:0] a, wd, rd;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .sel(sel), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the number of cycles left in the
  // frame currently on the wire (0 = line idle).
  logic [7:0] mq[$];
  int         busy_left;
  logic [7:0] cur;
  logic       m_en, m_ovf;

  task automatic model_reset();
    mq.delete();
    busy_left = 0;
    cur = 8'h00;
    m_en = 1'b1;
    m_ovf = 1'b0;
  endtask

  function automatic logic m_sel(input logic [31:0] addr);
    logic [31:0] w = addr >> 2;
    return (w >= (BASE >> 2)) && (w < (BASE >> 2) + 32'd3);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] addr);
    logic [31:0] off;
    logic [31:0] st;
    if (!m_sel(addr)) return 32'h0;
    off = (addr >> 2) - (BASE >> 2);
    st = 32'(busy_left > 0) | (32'(mq.size() == 0) << 1) | (32'(mq.size() == D) << 2)
       | (32'(m_ovf) << 3) | (32'(m_en) << 4) | (32'(mq.size()) << 8);
    if (off == 1) return st;
    if (off == 2) return {31'b0, m_en};
    return 32'h0;
  endfunction

  function automatic logic m_tx();
    int phase, idx;
    if (busy_left == 0) return 1'b1;
    phase = 10 * C - busy_left;
    idx = phase / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_step(input logic w, input logic [31:0] addr, input logic [31:0] data);
    logic full_b, do_pop;
    logic [31:0] off;
    full_b = (mq.size() == D);
    do_pop = (busy_left == 0) && m_en && (mq.size() > 0);
    off = (addr >> 2) - (BASE >> 2);
    if (do_pop) cur = mq.pop_front();
    if (w && m_sel(addr) && off == 0) begin
      if (!full_b || do_pop) mq.push_back(data[7:0]);
      else m_ovf = 1'b1;
    end
    if (w && m_sel(addr) && off == 2) begin
      m_en = data[0];
      if (data[1]) m_ovf = 1'b0;
    end
    if (do_pop) busy_left = 10 * C;
    else if (busy_left > 0) busy_left--;
  endtask

  // One clock: drive, check against the model before the edge, then step it.
  task automatic cycle(input logic w, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd_s, output logic sel_s, output logic tx_s);
    we = w; a = addr; wd = data;
    #1;
    rd_s = rd; sel_s = sel; tx_s = tx;
    chk("model sel", 32'(sel), 32'(m_sel(addr)));
    chk("model rd", rd, m_rd(addr));
    chk("model tx", 32'(tx), 32'(m_tx()));
    @(posedge clk);
    model_step(w, addr, data);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] r;
  logic        s, t;
  logic        txrec[0:259];
  logic [9:0]  fr;
  logic [7:0]  by;
  int          pos, prev, zeros;

  initial begin
    reset = 1'b1; we = 1'b0; a = BASE + 32'd4; wd = 32'h0;
    model_reset();
    #3;
    chk("reset tx", 32'(tx), 32'h1);
    chk("reset status", rd, 32'h0000_0012);
    chk("reset sel", 32'(sel), 32'h1);
    do_reset();

    vecs[0]  = '{1'b0, BASE + 32'd0,  32'h0,  32'h0,  1'b1};
    vecs[1]  = '{1'b0, BASE + 32'd4,  32'h0,  32'h12, 1'b1};
    vecs[2]  = '{1'b0, BASE + 32'd8,  32'h0,  32'h1,  1'b1};
    vecs[3]  = '{1'b0, BASE + 32'd12, 32'h0,  32'h0,  1'b0};
    vecs[4]  = '{1'b0, 32'h0,         32'h0,  32'h0,  1'b0};
    vecs[5]  = '{1'b0, BASE + 32'd6,  32'h0,  32'h12, 1'b1};
    vecs[6]  = '{1'b1, BASE + 32'd12, 32'hFF, 32'h0,  1'b0};
    vecs[7]  = '{1'b0, BASE + 32'd4,  32'h0,  32'h12, 1'b1};
    vecs[8]  = '{1'b1, BASE + 32'd8,  32'h0,  32'h1,  1'b1};
    vecs[9]  = '{1'b0, BASE + 32'd8,  32'h0,  32'h0,  1'b1};
    vecs[10] = '{1'b0, BASE + 32'd4,  32'h0,  32'h02, 1'b1};
    vecs[11] = '{1'b1, BASE + 32'd8,  32'h1,  32'h0,  1'b1};
    vecs[12] = '{1'b0, BASE + 32'd8,  32'h0,  32'h1,  1'b1};
    vecs[13] = '{1'b0, BASE - 32'd4,  32'h0,  32'h0,  1'b0};
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].we, vecs[i].a, vecs[i].wd, r, s, t);
      chk($sformatf("vec%0d rd", i), r, vecs[i].exp_rd);
      chk($sformatf("vec%0d sel", i), 32'(s), 32'(vecs[i].exp_sel));
    end

    // Single 0x55 frame, bit by bit.
    do_reset();
    fr = {1'b1, 8'h55, 1'b0};
    cycle(1'b1, BASE, 32'h55, r, s, t);
    for (int j = 0; j <= 44; j++) begin
      cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
      chk($sformatf("0x55 tx c%0d", j), 32'(t), (j == 0 || j > 40) ? 32'h1 : 32'(fr[(j-1)/C]));
      chk($sformatf("0x55 busy c%0d", j), 32'(r[0]), 32'(j >= 1 && j <= 40));
      if (j == 41) chk("0x55 final status", r, 32'h0000_0012);
    end

    // Five back-to-back bytes, then an overflowing sixth.
    do_reset();
    for (int i = 0; i < 260; i++) txrec[i] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, BASE, 32'(i + 1), r, s, t);
      txrec[i] = t;
    end
    cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
    txrec[6] = t;
    chk("burst overflow status", r, 32'h0000_041D);
    for (int i = 7; i < 240; i++) begin
      cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
      txrec[i] = t;
    end
    pos = 0; prev = 0;
    for (int f = 0; f < 5; f++) begin
      while (pos < 200 && txrec[pos] != 1'b0) pos++;
      if (pos >= 200) begin
        chk($sformatf("burst frame%0d found", f), 32'h0, 32'h1);
        break;
      end
      for (int b = 0; b < 8; b++) by[b] = txrec[pos + C + C*b + C/2];
      chk($sformatf("burst frame%0d byte", f), 32'(by), 32'(f + 1));
      chk($sformatf("burst frame%0d start", f), 32'(txrec[pos + C/2]), 32'h0);
      chk($sformatf("burst frame%0d stop", f), 32'(txrec[pos + 9*C + C/2]), 32'h1);
      if (f > 0) chk($sformatf("burst frame%0d spacing", f), 32'(pos - prev), 32'(10*C + 1));
      prev = pos;
      pos += 10 * C;
    end
    chk("overflow still set", 32'(r[3]), 32'h1);
    cycle(1'b1, BASE + 32'd8, 32'h3, r, s, t);
    cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
    chk("overflow cleared", 32'(r[3]), 32'h0);
    chk("enable kept", 32'(r[4]), 32'h1);

    // Disabled transmitter holds the byte until enable returns.
    do_reset();
    cycle(1'b1, BASE + 32'd8, 32'h0, r, s, t);
    cycle(1'b1, BASE, 32'hA5, r, s, t);
    zeros = 0;
    for (int j = 0; j < 30; j++) begin
      cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
      if (t == 1'b0 || r[15:8] != 8'd1) zeros++;
    end
    chk("disabled hold", 32'(zeros), 32'h0);
    cycle(1'b1, BASE + 32'd8, 32'h1, r, s, t);
    cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
    chk("enable edge tx", 32'(t), 32'h1);
    chk("enable edge busy", 32'(r[0]), 32'h0);
    cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
    chk("enable start tx", 32'(t), 32'h0);
    chk("enable start busy", 32'(r[0]), 32'h1);

    // Asynchronous reset in the middle of a data bit.
    do_reset();
    cycle(1'b1, BASE, 32'h00, r, s, t);
    cycle(1'b1, BASE, 32'h81, r, s, t);
    cycle(1'b1, BASE, 32'h7E, r, s, t);
    for (int j = 0; j < 10; j++) cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
    chk("pre-reset tx low", 32'(tx), 32'h0);
    #2;
    reset = 1'b1;
    a = BASE + 32'd4;
    #1;
    chk("async reset tx", 32'(tx), 32'h1);
    chk("status in reset", rd, 32'h0000_0012);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    zeros = 0;
    for (int j = 0; j < 60; j++) begin
      cycle(1'b0, BASE + 32'd4, 32'h0, r, s, t);
      if (j == 0) chk("post-reset status", r, 32'h0000_0012);
      if (t == 1'b0) zeros++;
    end
    chk("no frame after reset", 32'(zeros), 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      logic        rw;
      logic [31:0] ra, rdata;
      int          pick;
      rw = ($urandom_range(0, 3) == 0);
      pick = $urandom_range(0, 9);
      if (pick <= 4)      ra = BASE;
      else if (pick <= 6) ra = BASE + 32'd4;
      else if (pick == 7) ra = BASE + 32'd8;
      else if (pick == 8) ra = BASE + 32'd12;
      else                ra = $urandom;
      ra = {ra[31:2], 2'(ra[1:0] | 2'($urandom_range(0, 3)))};
      rdata = $urandom;
      if (pick == 7) rdata[0] = ($urandom_range(0, 3) != 0);
      cycle(rw, ra, rdata, r, s, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
